// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared widths, control-word field positions and stage
// subset extraction helpers for the control pipeline.
//   ID/EX word : {alu_op[1:0], reg_dst, branch, mem_read, mem_2_reg,
//                 mem_write, alu_src, reg_write, jump}   (bit 9 .. bit 0)
//   EX/MEM word: {branch, mem_read, mem_2_reg, mem_write, reg_write, jump}
//   MEM/WB word: {mem_2_reg, reg_write}
package ctrl_pipe_pkg;

  localparam int unsigned CTRL_W     = 10;
  localparam int unsigned MEM_CTRL_W = 6;
  localparam int unsigned WB_CTRL_W  = 2;

  // Field positions in the full decoder control word
  localparam int unsigned BIT_JUMP      = 0;
  localparam int unsigned BIT_REG_WRITE = 1;
  localparam int unsigned BIT_ALU_SRC   = 2;
  localparam int unsigned BIT_MEM_WRITE = 3;
  localparam int unsigned BIT_MEM_2_REG = 4;
  localparam int unsigned BIT_MEM_READ  = 5;
  localparam int unsigned BIT_BRANCH    = 6;
  localparam int unsigned BIT_REG_DST   = 7;
  localparam int unsigned BIT_ALU_OP_LO = 8;
  localparam int unsigned BIT_ALU_OP_HI = 9;

  // Field positions in the EX/MEM control word
  localparam int unsigned MEM_BIT_JUMP      = 0;
  localparam int unsigned MEM_BIT_REG_WRITE = 1;
  localparam int unsigned MEM_BIT_MEM_WRITE = 2;
  localparam int unsigned MEM_BIT_MEM_2_REG = 3;
  localparam int unsigned MEM_BIT_MEM_READ  = 4;
  localparam int unsigned MEM_BIT_BRANCH    = 5;

  // Field positions in the MEM/WB control word
  localparam int unsigned WB_BIT_REG_WRITE = 0;
  localparam int unsigned WB_BIT_MEM_2_REG = 1;

  // Bubble: every control bit cleared, including alu_op
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  // ID/EX word -> EX/MEM word, pure bit selection
  function automatic logic [MEM_CTRL_W-1:0] id_to_mem(input logic [CTRL_W-1:0] c);
    return {c[BIT_BRANCH], c[BIT_MEM_READ], c[BIT_MEM_2_REG],
            c[BIT_MEM_WRITE], c[BIT_REG_WRITE], c[BIT_JUMP]};
  endfunction

  // EX/MEM word -> MEM/WB word, pure bit selection
  function automatic logic [WB_CTRL_W-1:0] mem_to_wb(input logic [MEM_CTRL_W-1:0] c);
    return {c[MEM_BIT_MEM_2_REG], c[MEM_BIT_REG_WRITE]};
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: one pipeline stage register.
//   clk, arst_n : clock, asynchronous active-low reset (clears to zero)
//   en          : capture enable; 0 holds the current contents
//   clr         : synchronous clear when enabled (loads a bubble)
//   d / q       : stage payload in / out
module pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next value: hold unless enabled, clear takes priority over load
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = clr ? '0 : d;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: control-path ID/EX, EX/MEM and MEM/WB registers with
// load-use hazard detection, bubble insertion, branch/jump flush and a
// saturating load-use bubble counter.
//   clk, arst_n         : clock, asynchronous active-low reset
//   enable              : global advance; 0 freezes all state
//   flush               : taken branch/jump in MEM, squashes ID/EX and EX/MEM
//   id_ctrl, id_rs1/rs2/rd : instruction currently in ID
//   ex_*, mem_*, wb_*   : registered stage control words and destinations
//   load_use_stall      : combinational; upstream holds PC and IF/ID
//   bubble_cnt          : load-use bubbles inserted since reset
module ctrl_pipeline
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [MEM_CTRL_W-1:0] mem_ctrl,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [WB_CTRL_W-1:0]  wb_ctrl,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  load_use_stall,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam int unsigned IDEX_W  = CTRL_W + REG_ADDR_W;
  localparam int unsigned EXMEM_W = MEM_CTRL_W + REG_ADDR_W;
  localparam int unsigned MEMWB_W = WB_CTRL_W + REG_ADDR_W;

  logic                  hazard_raw;
  logic [IDEX_W-1:0]     idex_q;
  logic [EXMEM_W-1:0]    exmem_q;
  logic [MEMWB_W-1:0]    memwb_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;

  // Load in EX whose destination feeds the instruction in ID; x0 never hazards
  assign hazard_raw = ex_ctrl[BIT_MEM_READ]
                    & (ex_rd != '0)
                    & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // A flush kills the dependent instruction, so no stall is needed
  assign load_use_stall = hazard_raw & ~flush;

  // ID/EX: bubble on flush or load-use, otherwise capture from decode
  pipe_reg #(.W(IDEX_W)) u_idex (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (enable),
    .clr    (flush | hazard_raw),
    .d      ({id_ctrl, id_rd}),
    .q      (idex_q)
  );

  // EX/MEM: bubble on flush; on load-use the load still advances
  pipe_reg #(.W(EXMEM_W)) u_exmem (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (enable),
    .clr    (flush),
    .d      ({id_to_mem(ex_ctrl), ex_rd}),
    .q      (exmem_q)
  );

  // MEM/WB: the branch in MEM itself always completes
  pipe_reg #(.W(MEMWB_W)) u_memwb (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (enable),
    .clr    (1'b0),
    .d      ({mem_to_wb(mem_ctrl), mem_rd}),
    .q      (memwb_q)
  );

  assign {ex_ctrl, ex_rd}   = idex_q;
  assign {mem_ctrl, mem_rd} = exmem_q;
  assign {wb_ctrl, wb_rd}   = memwb_q;

  // Bubble counter: counts only bubbles actually inserted, saturates at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (enable && !flush && hazard_raw && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed self-checking bench for ctrl_pipeline.
// A second instance with a 2-bit counter shares all inputs to cover saturation.
module tb_ctrl_pipeline;

  logic        clk;
  logic        arst_n;
  logic        enable;
  logic        flush;
  logic [9:0]  id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [9:0]  ex_ctrl;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic [5:0]  mem_ctrl;
  logic [1:0]  wb_ctrl;
  logic        load_use_stall;
  logic [31:0] bubble_cnt;

  logic [9:0]  s_ex_ctrl;
  logic [4:0]  s_ex_rd, s_mem_rd, s_wb_rd;
  logic [5:0]  s_mem_ctrl;
  logic [1:0]  s_wb_ctrl;
  logic        s_load_use_stall;
  logic [1:0]  s_bubble_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] NOP = 10'b00_0000_0000;
  localparam logic [9:0] ADD = 10'b10_0000_0010;
  localparam logic [9:0] LD  = 10'b00_0011_0110;
  localparam logic [9:0] BRJ = 10'b01_0100_0001;

  ctrl_pipeline #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .flush(flush),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
    .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .load_use_stall(load_use_stall),
    .bubble_cnt(bubble_cnt)
  );

  ctrl_pipeline #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .arst_n(arst_n), .enable(enable), .flush(flush),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_ctrl(s_ex_ctrl), .ex_rd(s_ex_rd), .mem_ctrl(s_mem_ctrl), .mem_rd(s_mem_rd),
    .wb_ctrl(s_wb_ctrl), .wb_rd(s_wb_rd), .load_use_stall(s_load_use_stall),
    .bubble_cnt(s_bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_pipe(input string tag,
                          input logic [9:0] e_ex, input logic [4:0] e_exrd,
                          input logic [5:0] e_mem, input logic [4:0] e_memrd,
                          input logic [1:0] e_wb, input logic [4:0] e_wbrd);
    chk({tag, "/ex_ctrl"},  32'(ex_ctrl),  32'(e_ex));
    chk({tag, "/ex_rd"},    32'(ex_rd),    32'(e_exrd));
    chk({tag, "/mem_ctrl"}, 32'(mem_ctrl), 32'(e_mem));
    chk({tag, "/mem_rd"},   32'(mem_rd),   32'(e_memrd));
    chk({tag, "/wb_ctrl"},  32'(wb_ctrl),  32'(e_wb));
    chk({tag, "/wb_rd"},    32'(wb_rd),    32'(e_wbrd));
  endtask

  task automatic set_id(input logic [9:0] c, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd);
    id_ctrl = c;
    id_rs1  = rs1;
    id_rs2  = rs2;
    id_rd   = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n = 1'b1;
    enable = 1'b1;
    flush  = 1'b0;
    set_id(NOP, 0, 0, 0);
    #1 arst_n = 1'b0;
    #1;
    // Reset state
    chk_pipe("reset", NOP, 0, 6'h00, 0, 2'b00, 0);
    chk("reset/stall", 32'(load_use_stall), 32'd0);
    chk("reset/cnt", bubble_cnt, 32'd0);
    #1 arst_n = 1'b1;

    // Flow: ADD rd=5 then NOP
    set_id(ADD, 0, 0, 5);
    tick();
    chk_pipe("flow1", ADD, 5, 6'h00, 0, 2'b00, 0);
    set_id(NOP, 0, 0, 0);
    tick();
    chk_pipe("flow2", NOP, 0, 6'b000010, 5, 2'b00, 0);
    tick();
    chk_pipe("flow3", NOP, 0, 6'h00, 0, 2'b01, 5);

    // Load-use on rs2
    set_id(LD, 0, 0, 7);
    tick();
    chk_pipe("ld_in_ex", LD, 7, 6'h00, 0, 2'b00, 0);
    set_id(ADD, 3, 7, 9);
    #1;
    chk("lu/stall_hi", 32'(load_use_stall), 32'd1);
    tick();
    chk_pipe("lu/bubble", NOP, 0, 6'b011010, 7, 2'b00, 0);
    chk("lu/stall_lo", 32'(load_use_stall), 32'd0);
    chk("lu/cnt1", bubble_cnt, 32'd1);
    tick();
    chk_pipe("lu/resume", ADD, 9, 6'h00, 0, 2'b11, 7);
    chk("lu/cnt_hold", bubble_cnt, 32'd1);

    // Load with rd=0 never stalls
    set_id(LD, 0, 0, 0);
    tick();
    set_id(ADD, 0, 0, 9);
    #1;
    chk("x0/stall", 32'(load_use_stall), 32'd0);
    tick();
    chk("x0/ex_ctrl", 32'(ex_ctrl), 32'(ADD));
    chk("x0/cnt", bubble_cnt, 32'd1);

    // Flush with three distinct instructions in MEM/EX/ID
    set_id(LD, 0, 0, 4);
    tick();
    set_id(BRJ, 0, 0, 0);
    tick();
    set_id(ADD, 0, 0, 9);
    flush = 1'b1;
    tick();
    chk_pipe("flush", NOP, 0, 6'h00, 0, 2'b11, 4);
    flush = 1'b0;

    // Flush together with a load-use hazard
    set_id(LD, 0, 0, 7);
    tick();
    set_id(ADD, 7, 0, 9);
    flush = 1'b1;
    #1;
    chk("flush_hz/stall", 32'(load_use_stall), 32'd0);
    tick();
    chk("flush_hz/ex", 32'(ex_ctrl), 32'(NOP));
    chk("flush_hz/cnt", bubble_cnt, 32'd1);
    flush = 1'b0;

    // Freeze with flush and hazard present
    set_id(ADD, 0, 0, 3);
    tick();
    set_id(LD, 0, 0, 7);
    tick();
    chk_pipe("pre_freeze", LD, 7, 6'b000010, 3, 2'b00, 0);
    set_id(ADD, 7, 0, 9);
    flush  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pipe("freeze", LD, 7, 6'b000010, 3, 2'b00, 0);
      chk("freeze/cnt", bubble_cnt, 32'd1);
    end
    flush  = 1'b0;
    enable = 1'b1;
    #1;
    chk("unfreeze/stall", 32'(load_use_stall), 32'd1);
    tick();
    chk_pipe("unfreeze", NOP, 0, 6'b011010, 7, 2'b01, 3);
    chk("unfreeze/cnt", bubble_cnt, 32'd2);
    tick();
    chk("unfreeze/ex", 32'(ex_ctrl), 32'(ADD));

    // Mid-operation reset
    arst_n = 1'b0;
    #1;
    chk_pipe("rst_mid", NOP, 0, 6'h00, 0, 2'b00, 0);
    chk("rst_mid/stall", 32'(load_use_stall), 32'd0);
    chk("rst_mid/cnt", bubble_cnt, 32'd0);
    chk("rst_mid/sat_cnt", 32'(s_bubble_cnt), 32'd0);
    #1 arst_n = 1'b1;

    // Saturation: five bubbles, 2-bit counter reads 1,2,3,3,3
    for (int k = 1; k <= 5; k++) begin
      set_id(LD, 0, 0, 7);
      tick();
      set_id(ADD, 0, 7, 9);
      tick();
      chk("sat/cnt32", bubble_cnt, 32'(k));
      chk("sat/cnt2", 32'(s_bubble_cnt), (k > 3) ? 32'd3 : 32'(k));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
